// File: rtl/rv_opcode_pkg.sv
// RV64I major-opcode constants (inst[6:2]) shared by decode, control and hazard logic.
package rv_opcode_pkg;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OPC_LOAD      = 5'b00000;
  localparam opcode_t OPC_MISC_MEM  = 5'b00011;
  localparam opcode_t OPC_OP_IMM    = 5'b00100;
  localparam opcode_t OPC_AUIPC     = 5'b00101;
  localparam opcode_t OPC_OP_IMM_32 = 5'b00110;
  localparam opcode_t OPC_STORE     = 5'b01000;
  localparam opcode_t OPC_OP        = 5'b01100;
  localparam opcode_t OPC_LUI       = 5'b01101;
  localparam opcode_t OPC_OP_32     = 5'b01110;
  localparam opcode_t OPC_BRANCH    = 5'b11000;
  localparam opcode_t OPC_JALR      = 5'b11001;
  localparam opcode_t OPC_JAL       = 5'b11011;
  localparam opcode_t OPC_SYSTEM    = 5'b11100;

endpackage

// File: rtl/reg_use_decode.sv
// Which architectural register fields an opcode actually reads or writes.
module reg_use_decode
  import rv_opcode_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load
);

  always_comb begin
    uses_rs1  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    uses_rs2  = (opcode == OPC_STORE) || (opcode == OPC_BRANCH) ||
                (opcode == OPC_OP)    || (opcode == OPC_OP_32);
    writes_rd = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH));
    is_load   = (opcode == OPC_LOAD);
  end

endmodule

// File: rtl/load_scoreboard.sv
// Issue-stage load scoreboard: busy map of pending load destinations, RAW/WAW/capacity
// stalls, and a drain state that holds issue after a flush until all loads return.
module load_scoreboard
  import rv_opcode_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_opcode,
  input  logic [4:0]       id_rs1_index,
  input  logic [4:0]       id_rs2_index,
  input  logic [4:0]       id_rd_index,
  input  logic             ex_ready,
  output logic             id_ready,
  output logic             issue_fire,
  input  logic             flush,
  input  logic             ld_wb_valid,
  input  logic [4:0]       ld_wb_rd_index,
  output logic [31:0]      busy_map,
  output logic [CNT_W-1:0] outstanding,
  output logic             draining,
  output logic             err
);

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  state_t           state_reg;
  logic [31:0]      busy_reg;
  logic [31:0]      busy_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             err_reg;
  logic             err_next;

  logic uses_rs1, uses_rs2, writes_rd, is_load;
  logic raw, waw, full, load_fire;

  reg_use_decode u_decode (
    .opcode    (id_opcode),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load)
  );

  // Hazards look only at the registered map: a writeback frees its consumer next cycle.
  assign raw  = (uses_rs1 & busy_reg[id_rs1_index]) | (uses_rs2 & busy_reg[id_rs2_index]);
  assign waw  = writes_rd & (id_rd_index != 5'd0) & busy_reg[id_rd_index];
  assign full = is_load & (cnt_reg == CNT_W'(MAX_OUTSTANDING));

  assign id_ready   = (state_reg == ST_RUN) & !flush & !raw & !waw & !full;
  assign issue_fire = id_valid & id_ready & ex_ready;
  assign load_fire  = issue_fire & is_load;

  // Per-register update: writeback clear first, then issue set; x0 is never tracked.
  assign busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (busy_reg[gi] & !(ld_wb_valid && (ld_wb_rd_index == 5'(gi)))) |
                             (load_fire && (id_rd_index == 5'(gi)));
    end
  endgenerate

  always_comb begin
    cnt_next = cnt_reg;
    if (load_fire && !ld_wb_valid)
      cnt_next = cnt_reg + CNT_W'(1);
    else if (!load_fire && ld_wb_valid && (cnt_reg != '0))
      cnt_next = cnt_reg - CNT_W'(1);
  end

  assign err_next = err_reg |
                    (ld_wb_valid & ((cnt_reg == '0) |
                                    ((ld_wb_rd_index != 5'd0) & !busy_reg[ld_wb_rd_index])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      busy_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
      // Leaving DRAIN tracks the counter reaching zero so both change on the same edge.
      case (state_reg)
        ST_RUN:   if (flush && (cnt_next != '0)) state_reg <= ST_DRAIN;
        ST_DRAIN: if (!flush && (cnt_next == '0)) state_reg <= ST_RUN;
        default:  state_reg <= ST_RUN;
      endcase
    end
  end

  assign busy_map    = busy_reg;
  assign outstanding = cnt_reg;
  assign draining    = (state_reg == ST_DRAIN);
  assign err         = err_reg;

endmodule

// File: tb/tb_load_scoreboard.sv
// Table-driven bench for load_scoreboard with a queue of expected post-edge state.
module tb_load_scoreboard;
  import rv_opcode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_opcode, id_rs1_index, id_rs2_index, id_rd_index;
  logic        ex_ready, id_ready, issue_fire, flush;
  logic        ld_wb_valid;
  logic [4:0]  ld_wb_rd_index;
  logic [31:0] busy_map;
  logic [3:0]  outstanding;
  logic        draining, err;

  int total = 0;
  int bad   = 0;

  load_scoreboard #(.MAX_OUTSTANDING(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index), .id_rd_index(id_rd_index),
    .ex_ready(ex_ready), .id_ready(id_ready), .issue_fire(issue_fire), .flush(flush),
    .ld_wb_valid(ld_wb_valid), .ld_wb_rd_index(ld_wb_rd_index), .busy_map(busy_map),
    .outstanding(outstanding), .draining(draining), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [4:0] op, rs1, rs2, rd; logic exr, fl, wv; logic [4:0] wrd;
    logic e_rdy, e_fire; logic [31:0] e_busy; logic [3:0] e_out; logic e_drn, e_err;
  } vec_t;

  typedef struct { int id; logic [31:0] busy; logic [3:0] out; logic drn, err; } post_t;

  vec_t  vecs[$];
  post_t post_q[$];

  function automatic vec_t mk(logic v, logic [4:0] op, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic exr, logic fl, logic wv, logic [4:0] wrd,
                              logic e_rdy, logic e_fire, logic [31:0] e_busy,
                              logic [3:0] e_out, logic e_drn, logic e_err);
    vec_t r;
    r.v = v; r.op = op; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.exr = exr; r.fl = fl;
    r.wv = wv; r.wrd = wrd; r.e_rdy = e_rdy; r.e_fire = e_fire; r.e_busy = e_busy;
    r.e_out = e_out; r.e_drn = e_drn; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(string name, int id, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, id, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after an edge, check handshake, then check state.
  task automatic apply(int id, vec_t t);
    post_t p, got;
    id_valid = t.v; id_opcode = t.op; id_rs1_index = t.rs1; id_rs2_index = t.rs2;
    id_rd_index = t.rd; ex_ready = t.exr; flush = t.fl;
    ld_wb_valid = t.wv; ld_wb_rd_index = t.wrd;
    p.id = id; p.busy = t.e_busy; p.out = t.e_out; p.drn = t.e_drn; p.err = t.e_err;
    post_q.push_back(p);
    #1;
    chk("id_ready", id, 32'(id_ready), 32'(t.e_rdy));
    chk("issue_fire", id, 32'(issue_fire), 32'(t.e_fire));
    @(posedge clk);
    #1;
    got = post_q.pop_front();
    chk("busy_map", got.id, busy_map, got.busy);
    chk("outstanding", got.id, 32'(outstanding), 32'(got.out));
    chk("draining", got.id, 32'(draining), 32'(got.drn));
    chk("err", got.id, 32'(err), 32'(got.err));
    $display("step %0d: op=%0d rd=%0d wb=%0b/%0d busy=%h out=%0d drn=%0b err=%0b",
             id, t.op, t.rd, t.wv, t.wrd, busy_map, outstanding, draining, err);
    ld_wb_valid = 1'b0; flush = 1'b0; id_valid = 1'b0;
  endtask

  task automatic async_reset_check(int id);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", id, busy_map, 32'h0);
    chk("rst_out", id, 32'(outstanding), 32'h0);
    chk("rst_drn", id, 32'(draining), 32'h0);
    chk("rst_err", id, 32'(err), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 0; id_opcode = OPC_LOAD; id_rs1_index = 0; id_rs2_index = 0;
    id_rd_index = 0; ex_ready = 1; flush = 0; ld_wb_valid = 0; ld_wb_rd_index = 0;

    //              v  op            rs1 rs2 rd exr fl wv wrd rdy fire busy          out drn err
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 5,  1, 0, 0, 0,  1, 1, 32'h0000_0020, 1, 0, 0));
    vecs.push_back(mk(1, OPC_OP,       5, 1, 6,  1, 0, 0, 0,  0, 0, 32'h0000_0020, 1, 0, 0));
    vecs.push_back(mk(1, OPC_OP,       5, 1, 6,  1, 0, 1, 5,  0, 0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1, OPC_OP,       5, 1, 6,  1, 0, 0, 0,  1, 1, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 7,  1, 0, 0, 0,  1, 1, 32'h0000_0080, 1, 0, 0));
    vecs.push_back(mk(1, OPC_LUI,      7, 7, 7,  1, 0, 0, 0,  0, 0, 32'h0000_0080, 1, 0, 0));
    vecs.push_back(mk(1, OPC_OP_IMM,   7, 0, 1,  1, 0, 0, 0,  0, 0, 32'h0000_0080, 1, 0, 0));
    vecs.push_back(mk(1, OPC_STORE,    0, 7, 7,  1, 0, 0, 0,  0, 0, 32'h0000_0080, 1, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 9,  1, 0, 0, 0,  1, 1, 32'h0000_0280, 2, 0, 0));
    vecs.push_back(mk(1, OPC_LUI,      9, 9, 2,  1, 0, 0, 0,  1, 1, 32'h0000_0280, 2, 0, 0));
    vecs.push_back(mk(1, OPC_JAL,      9, 9, 3,  1, 0, 0, 0,  1, 1, 32'h0000_0280, 2, 0, 0));
    vecs.push_back(mk(1, OPC_OP_IMM,   0, 9, 0,  1, 0, 1, 7,  1, 1, 32'h0000_0200, 1, 0, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 0, 1, 9,  1, 0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 1,  1, 0, 0, 0,  1, 1, 32'h0000_0002, 1, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 2,  1, 0, 0, 0,  1, 1, 32'h0000_0006, 2, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 3,  1, 0, 0, 0,  1, 1, 32'h0000_000E, 3, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 4,  1, 0, 0, 0,  1, 1, 32'h0000_001E, 4, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 10, 1, 0, 0, 0,  0, 0, 32'h0000_001E, 4, 0, 0));
    vecs.push_back(mk(1, OPC_OP,      12, 13, 11, 1, 0, 0, 0, 1, 1, 32'h0000_001E, 4, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 10, 1, 0, 1, 1,  0, 0, 32'h0000_001C, 3, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 10, 1, 0, 0, 0,  1, 1, 32'h0000_041C, 4, 0, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 0, 1, 2,  0, 0, 32'h0000_0418, 3, 0, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 0, 1, 3,  1, 0, 32'h0000_0410, 2, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 8,  1, 0, 1, 4,  1, 1, 32'h0000_0500, 2, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 12, 0, 0, 0, 0,  1, 0, 32'h0000_0500, 2, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 12, 1, 1, 0, 0,  0, 0, 32'h0000_0500, 2, 1, 0));
    vecs.push_back(mk(1, OPC_OP,       0, 0, 1,  1, 0, 1, 8,  0, 0, 32'h0000_0400, 1, 1, 0));
    vecs.push_back(mk(1, OPC_OP,       0, 0, 1,  1, 0, 1, 10, 0, 0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1, OPC_OP,       0, 0, 1,  1, 0, 0, 0,  1, 1, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(1, OPC_LOAD,     0, 0, 5,  1, 0, 0, 0,  1, 1, 32'h0000_0020, 1, 0, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 1, 0, 0,  0, 0, 32'h0000_0020, 1, 1, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 1, 1, 5,  0, 0, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 0, 0, 0,  0, 0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 1, 0, 0,  0, 0, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 0, 1, 6,  1, 0, 32'h0000_0000, 0, 0, 1));
    vecs.push_back(mk(0, OPC_LOAD,     0, 0, 0,  1, 0, 0, 0,  1, 0, 32'h0000_0000, 0, 0, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_busy", 0, busy_map, 32'h0);
    chk("reset_out", 0, 32'(outstanding), 32'h0);
    chk("reset_drn", 0, 32'(draining), 32'h0);
    chk("reset_err", 0, 32'(err), 32'h0);
    chk("reset_ready", 0, 32'(id_ready), 32'h1);

    for (int i = 0; i < vecs.size(); i++) apply(i + 1, vecs[i]);

    // Asynchronous reset in the middle of a drain, then a stale writeback.
    apply(101, mk(1, OPC_LOAD, 0, 0, 3, 1, 0, 0, 0, 1, 1, 32'h0000_0008, 1, 0, 1));
    apply(102, mk(0, OPC_LOAD, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0000_0008, 1, 1, 1));
    async_reset_check(103);
    apply(104, mk(0, OPC_LOAD, 0, 0, 0, 1, 0, 1, 3, 1, 0, 32'h0000_0000, 0, 0, 1));

    // Writeback to a register that is not busy: err set, counter still decrements.
    async_reset_check(105);
    apply(106, mk(1, OPC_LOAD, 0, 0, 3, 1, 0, 0, 0, 1, 1, 32'h0000_0008, 1, 0, 0));
    apply(107, mk(0, OPC_LOAD, 0, 0, 0, 1, 0, 1, 4, 1, 0, 32'h0000_0008, 0, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
